// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 key-matrix scanner.
// Key index convention: row*COLS + col.
package keypad_pkg;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int NUM_KEYS = ROWS * COLS;
  localparam int ROW_W    = $clog2(ROWS);

  typedef logic [3:0]          key_code_t;
  typedef logic [NUM_KEYS-1:0] key_map_t;

  // Lowest-index set bit wins; returns 0 for an empty map (callers gate on |m).
  function automatic key_code_t lowest_key(input key_map_t m);
    key_code_t code;
    code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (m[i]) code = key_code_t'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running divider that emits a one-clock enable pulse every DIV clocks.
// The pulse is a clock enable, never a derived clock.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key-matrix scanner: row strobing, frame debounce, and a valid/ready
// stream of press events (one per rising key, lowest index first).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int SCAN_FREQ_HZ    = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] rows_out,
  input  logic [COLS-1:0] cols_in,
  output key_map_t        pressed,
  output logic            key_valid,
  output key_code_t       key_code,
  input  logic            key_ready
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_FREQ_HZ;
  localparam int SW  = (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [SW-1:0] CNT_MAX  = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] CNT_FIRE = SW'(DEBOUNCE_FRAMES - 1);

  if (DIV < 4) begin : g_bad_div
    $error("keypad_scanner: CLK_FREQ_HZ/SCAN_FREQ_HZ must be >= 4");
  end
  if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_FRAMES must be >= 1");
  end

  logic tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Column sense is asynchronous to clk.
  logic [COLS-1:0] cols_s1;
  logic [COLS-1:0] cols_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_s1 <= '0;
      cols_s2 <= '0;
    end else begin
      cols_s1 <= cols_in;
      cols_s2 <= cols_s1;
    end
  end

  logic [ROW_W-1:0] row_idx;
  logic             frame_end;

  assign frame_end = tick && (row_idx == ROW_W'(ROWS - 1));

  always_comb begin
    rows_out          = '0;
    rows_out[row_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= '0;
    end else if (tick) begin
      row_idx <= row_idx + 1'b1;
    end
  end

  // frame_full is the snapshot with the current row's columns merged in; on a
  // tick it is the next snapshot, and at frame end it is the completed frame.
  key_map_t snapshot;
  key_map_t frame_full;
  key_map_t prev_frame;
  logic     frame_eq;

  always_comb begin
    frame_full = snapshot;
    for (int r = 0; r < ROWS; r++) begin
      if (row_idx == ROW_W'(r)) frame_full[r*COLS +: COLS] = cols_s2;
    end
  end

  assign frame_eq = (frame_full == prev_frame);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
    end else if (tick) begin
      snapshot <= frame_full;
    end
  end

  logic [SW-1:0] stable_cnt;
  logic          pressed_upd;
  key_map_t      rising;

  assign pressed_upd = frame_end && frame_eq && (stable_cnt == CNT_FIRE);
  assign rising      = pressed_upd ? (frame_full & ~pressed) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_frame <= '0;
      stable_cnt <= '0;
      pressed    <= '0;
    end else if (frame_end) begin
      prev_frame <= frame_full;
      if (!frame_eq) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      if (pressed_upd) pressed <= frame_full;
    end
  end

  // Valid/ready contract: key_valid/key_code are held while key_valid & ~key_ready;
  // a transfer happens on any clock with key_valid & key_ready, and the register
  // refills from pending on that same clock, giving one event per clock under
  // continuous ready.
  key_map_t  pending;
  key_map_t  pending_next;
  logic      valid_next;
  key_code_t code_next;
  logic      out_load;

  assign out_load = !key_valid || key_ready;

  // New rising bits OR in after the loaded bit's clear, so a press that lands on
  // a load cycle is never lost and a re-press of a pending key coalesces.
  always_comb begin
    pending_next = pending;
    valid_next   = key_valid;
    code_next    = key_code;
    if (out_load) begin
      if (|pending) begin
        valid_next              = 1'b1;
        code_next               = lowest_key(pending);
        pending_next[code_next] = 1'b0;
      end else begin
        valid_next = 1'b0;
      end
    end
    pending_next = pending_next | rising;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      pending   <= pending_next;
      key_valid <= valid_next;
      key_code  <= code_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model, frame-level reference model,
// directed scenarios with literal expectations, then randomized key activity.
module tb_keypad_scanner;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int DF      = 2;
  localparam int DIV     = CLK_HZ / SCAN_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows_out;
  logic [3:0]  cols_in;
  logic [15:0] pressed;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;

  keypad_scanner #(
    .CLK_FREQ_HZ     (CLK_HZ),
    .SCAN_FREQ_HZ    (SCAN_HZ),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rows_out  (rows_out),
    .cols_in   (cols_in),
    .pressed   (pressed),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Key matrix: a closed key connects its row drive to its column line.
  always_comb begin
    cols_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (rows_out[r] && keys[r*4+c]) cols_in[c] = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: scan position from a clock count, frames as whole
  // 16-bit words, debounce as "last DF+1 frames identical", events as a set.
  int          m_cnt;
  int          m_row;
  logic [3:0]  m_s1, m_s2;
  logic [15:0] m_frame;
  logic [15:0] hist[$];
  logic [15:0] m_pressed;
  logic [15:0] m_pend;
  logic        m_valid;
  logic [3:0]  m_code;

  task automatic model_reset();
    m_cnt = 0; m_row = 0; m_s1 = '0; m_s2 = '0; m_frame = '0;
    hist.delete();
    hist.push_back(16'h0000);
    m_pressed = '0; m_pend = '0; m_valid = 1'b0; m_code = '0;
  endtask

  task automatic model_step();
    logic [3:0]  cols_now;
    logic [15:0] new_pressed;
    logic [15:0] rise;
    logic        all_eq;
    logic        found;
    cols_now = keys[m_row*4 +: 4];
    new_pressed = m_pressed;
    rise = '0;
    if (m_cnt == DIV - 1) begin
      m_frame[m_row*4 +: 4] = m_s2;
      if (m_row == 3) begin
        hist.push_back(m_frame);
        if (hist.size() > DF + 1) void'(hist.pop_front());
        all_eq = (hist.size() == DF + 1);
        for (int i = 1; i < hist.size(); i++)
          if (hist[i] != hist[0]) all_eq = 1'b0;
        if (all_eq) begin
          new_pressed = m_frame;
          rise = m_frame & ~m_pressed;
        end
      end
      m_row = (m_row + 1) % 4;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    if (!m_valid || key_ready) begin
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (!found && m_pend[i]) begin
          found = 1'b1;
          m_code = 4'(i);
          m_pend[i] = 1'b0;
        end
      end
      m_valid = found;
    end
    m_pend = m_pend | rise;
    m_pressed = new_pressed;
    m_s2 = m_s1;
    m_s1 = cols_now;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("rows_out", rows_out, 32'(4'b0001 << m_row));
      chk("pressed", pressed, m_pressed);
      chk("key_valid", key_valid, m_valid);
      if (m_valid) chk("key_code", key_code, m_code);
    end
  end

  // Scoreboard of accepted events.
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && key_valid && key_ready) got_q.push_back(key_code);
    end
  end

  task automatic check_events(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'hffff_ffff, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pressed(input logic [15:0] exp, input string name);
    int n = 0;
    while (pressed !== exp && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, pressed, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values and scan sequence
    cyc(3);
    chk("reset_rows", rows_out, 4'b0001);
    chk("reset_pressed", pressed, 16'h0000);
    chk("reset_valid", key_valid, 1'b0);
    chk("reset_code", key_code, 4'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("scan_row0", rows_out, 4'b0001);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("scan_row1", rows_out, 4'b0010);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("scan_row2", rows_out, 4'b0100);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("scan_row3", rows_out, 4'b1000);
    repeat (10) @(posedge clk);
    @(negedge clk); chk("scan_wrap", rows_out, 4'b0001);
    chk("scan_valid", key_valid, 1'b0);

    // single press of key 9 (row 2, col 1)
    cyc(1);
    keys = 16'h0200;
    wait_pressed(16'h0200, "press9");
    @(negedge clk);
    chk("press9_valid", key_valid, 1'b1);
    chk("press9_code", key_code, 4'd9);
    @(posedge clk); #2 key_ready = 1'b1;
    @(posedge clk); #2 key_ready = 1'b0;
    @(negedge clk); chk("press9_drained", key_valid, 1'b0);
    cyc(1);
    keys = '0;
    wait_pressed(16'h0000, "release9");
    cyc(20);
    exp_q.push_back(4'd9);
    check_events("ev_press9");

    // bounce rejection on key 5
    key_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      keys[5] = ~keys[5];
      cyc(40);
    end
    @(negedge clk); chk("bounce_pressed", pressed, 16'h0000);
    cyc(1);
    keys[5] = 1'b1;
    wait_pressed(16'h0020, "bounce_hold");
    cyc(5);
    exp_q.push_back(4'd5);
    check_events("ev_bounce");
    keys = '0;
    wait_pressed(16'h0000, "bounce_release");
    cyc(1);

    // multi-key ordering under backpressure
    key_ready = 1'b0;
    keys = 16'h1088;
    wait_pressed(16'h1088, "multi_pressed");
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      chk("multi_hold_valid", key_valid, 1'b1);
      chk("multi_hold_code", key_code, 4'd3);
      @(negedge clk);
    end
    @(posedge clk); #2 key_ready = 1'b1;
    cyc(5);
    key_ready = 1'b0;
    @(negedge clk); chk("multi_drained", key_valid, 1'b0);
    exp_q.push_back(4'd3); exp_q.push_back(4'd7); exp_q.push_back(4'd12);
    check_events("ev_multi");
    cyc(1);
    keys = '0;
    wait_pressed(16'h0000, "multi_release");
    cyc(1);

    // coalescing: key 3 occupies the output, key 0 pressed twice while pending
    keys = 16'h0008;
    wait_pressed(16'h0008, "coal_k3");
    cyc(1); keys = 16'h0009;
    wait_pressed(16'h0009, "coal_k0a");
    cyc(1); keys = 16'h0008;
    wait_pressed(16'h0008, "coal_rel0");
    cyc(1); keys = 16'h0009;
    wait_pressed(16'h0009, "coal_k0b");
    cyc(1); key_ready = 1'b1;
    cyc(6);
    key_ready = 1'b0;
    exp_q.push_back(4'd3); exp_q.push_back(4'd0);
    check_events("ev_coalesce");
    keys = '0;
    wait_pressed(16'h0000, "coal_release");
    cyc(1);

    // asynchronous reset mid-frame with an event held
    keys = 16'h0040;
    wait_pressed(16'h0040, "rst_press6");
    @(negedge clk);
    begin
      int n = 0;
      while (rows_out !== 4'b0100 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_row2_seen", rows_out, 4'b0100);
    chk("rst_pre_valid", key_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_rows", rows_out, 4'b0001);
    chk("rst_async_valid", key_valid, 1'b0);
    chk("rst_async_pressed", pressed, 16'h0000);
    keys = '0;
    cyc(3);
    rst_n = 1'b1;
    key_ready = 1'b1;
    cyc(200);
    chk("rst_no_stale", got_q.size(), 0);
    got_q.delete();

    // randomized key activity and backpressure
    for (int it = 0; it < 40; it++) begin
      int hold;
      int nk;
      int rdy_lo;
      logic [15:0] k;
      k = '0;
      nk = $urandom_range(0, 3);
      for (int j = 0; j < nk; j++) k[$urandom_range(0, 15)] = 1'b1;
      keys = k;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 40) : $urandom_range(60, 160);
      rdy_lo = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) begin
        key_ready = ($urandom_range(0, 3) >= rdy_lo);
        cyc(1);
      end
    end
    key_ready = 1'b1;
    keys = '0;
    cyc(200);
    @(negedge clk);
    chk("final_pressed", pressed, 16'h0000);
    chk("final_valid", key_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
